// File: rtl/aer_sample_sequencer.sv
// -----------------------------------------------------------------------------
// aer_sample_sequencer
//
// Plays one input sample into the SNN core's AER input port. Pixel intensities
// are read from an external synchronous sample RAM and rate-coded into spike
// events over TIME_STEP time steps. In step t, pixel n spikes when its
// intensity exceeds t * 2^SHIFT. Each step is closed by an end-of-step marker
// event on address TSTEP_ADDR. After the last step the sequencer waits for the
// core's sample-finished pulse, latches the core's goodness value and pulses
// DONE.
//
// Ports
//   CLK, RST          clock; asynchronous active-high reset
//   START             one-cycle start pulse, honoured only when idle
//   SAMPLE_IS_POS     sample polarity, latched on an accepted START
//   SAMPLE_IS_TRAIN   train/infer mode, latched on an accepted START
//   BUSY              sequencer is working on a sample
//   DONE              one-cycle pulse, GOODNESS is valid
//   PIX_REN/RADDR     sample RAM read port (address = pixel index)
//   PIX_RDATA         sample RAM data, valid one cycle after PIX_REN
//   AERIN_ADDR/REQ    4-phase AER event output to the core
//   AERIN_ACK         AER acknowledge from the core
//   IS_POS, IS_TRAIN  latched sample mode, held until the next START
//   CORE_DONE         core sample-finished pulse
//   CORE_GOODNESS     core goodness value, captured on CORE_DONE
//   GOODNESS          latched goodness value
// -----------------------------------------------------------------------------
module aer_sample_sequencer #(
   parameter int                 TIME_STEP       = 8,
   parameter int                 INPUT_NEURON    = 784,
   parameter int                 PIX_WIDTH       = 8,
   parameter int                 NEUR_ADDR_WIDTH = 10,
   parameter int                 AER_WIDTH       = 12,
   parameter logic [AER_WIDTH-1:0] TSTEP_ADDR    = 12'hFFF
) (
   input  logic                       CLK,
   input  logic                       RST,
   input  logic                       START,
   input  logic                       SAMPLE_IS_POS,
   input  logic                       SAMPLE_IS_TRAIN,
   output logic                       BUSY,
   output logic                       DONE,
   output logic                       PIX_REN,
   output logic [NEUR_ADDR_WIDTH-1:0] PIX_RADDR,
   input  logic [PIX_WIDTH-1:0]       PIX_RDATA,
   output logic [AER_WIDTH-1:0]       AERIN_ADDR,
   output logic                       AERIN_REQ,
   input  logic                       AERIN_ACK,
   output logic                       IS_POS,
   output logic                       IS_TRAIN,
   input  logic                       CORE_DONE,
   input  logic [31:0]                CORE_GOODNESS,
   output logic [31:0]                GOODNESS
);

   // Step counter width; a single-step configuration still needs one bit.
   localparam int TS_LOG = $clog2(TIME_STEP);
   localparam int TW     = (TS_LOG > 0) ? TS_LOG : 1;
   // Threshold scale: step t compares against t << SHIFT.
   localparam int SHIFT  = PIX_WIDTH - TS_LOG;

   typedef enum logic [2:0] {
      S_IDLE,
      S_READ,
      S_EVAL,
      S_REQ,
      S_ACKL,
      S_TSTEP,
      S_WAIT_DONE,
      S_FIN
   } state_t;

   state_t                     state, state_nx;
   logic [NEUR_ADDR_WIDTH-1:0] n_q;          // current pixel / neuron index
   logic [TW-1:0]              t_q;          // current time step
   logic [AER_WIDTH-1:0]       addr_q;       // event address held on the bus
   logic                       ev_tstep_q;   // in-flight event is the step marker
   logic                       pos_q;
   logic                       train_q;
   logic [31:0]                good_q;

   logic [PIX_WIDTH-1:0]       thr;
   logic                       spike;
   logic                       last_n;
   logic                       last_t;
   logic                       advance;

   assign thr    = PIX_WIDTH'(t_q) << SHIFT;
   assign spike  = (PIX_RDATA > thr);
   assign last_n = (n_q == NEUR_ADDR_WIDTH'(INPUT_NEURON - 1));
   assign last_t = (t_q == TW'(TIME_STEP - 1));

   // Move on to the next pixel: either a pixel did not spike, or its spike
   // handshake has fully returned to idle.
   assign advance = ((state == S_EVAL) && !spike) ||
                    ((state == S_ACKL) && !AERIN_ACK && !ev_tstep_q);

   // --------------------------------------------------------------------------
   // State register
   // --------------------------------------------------------------------------
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) state <= S_IDLE;
      else     state <= state_nx;
   end

   // --------------------------------------------------------------------------
   // Next-state logic
   // --------------------------------------------------------------------------
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:      if (START) state_nx = S_READ;
         S_READ:      state_nx = S_EVAL;
         S_EVAL: begin
            if (spike)       state_nx = S_REQ;
            else if (last_n) state_nx = S_TSTEP;
            else             state_nx = S_READ;
         end
         S_REQ:       if (AERIN_ACK) state_nx = S_ACKL;
         S_TSTEP:     if (AERIN_ACK) state_nx = S_ACKL;
         S_ACKL: begin
            if (!AERIN_ACK) begin
               if (ev_tstep_q) state_nx = last_t ? S_WAIT_DONE : S_READ;
               else            state_nx = last_n ? S_TSTEP : S_READ;
            end
         end
         S_WAIT_DONE: if (CORE_DONE) state_nx = S_FIN;
         S_FIN:       state_nx = S_IDLE;
         default:     state_nx = S_IDLE;
      endcase
   end

   // --------------------------------------------------------------------------
   // Outputs decoded from state. REQ comes straight from the state register so
   // an asynchronous reset drops it immediately.
   // --------------------------------------------------------------------------
   always_comb begin
      BUSY      = (state != S_IDLE);
      PIX_REN   = (state == S_READ);
      AERIN_REQ = (state == S_REQ) || (state == S_TSTEP);
      DONE      = (state == S_FIN);
   end

   assign PIX_RADDR  = n_q;
   assign AERIN_ADDR = addr_q;
   assign IS_POS     = pos_q;
   assign IS_TRAIN   = train_q;
   assign GOODNESS   = good_q;

   // --------------------------------------------------------------------------
   // Datapath: indices, event address, latched mode and goodness.
   // addr_q is only written in EVAL/ACKL, where REQ is low, so the address is
   // stable for the whole request phase.
   // --------------------------------------------------------------------------
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         n_q        <= '0;
         t_q        <= '0;
         addr_q     <= '0;
         ev_tstep_q <= 1'b0;
         pos_q      <= 1'b0;
         train_q    <= 1'b0;
         good_q     <= '0;
      end else begin
         if ((state == S_IDLE) && START) begin
            pos_q   <= SAMPLE_IS_POS;
            train_q <= SAMPLE_IS_TRAIN;
            n_q     <= '0;
            t_q     <= '0;
         end

         if ((state == S_EVAL) && spike) begin
            addr_q     <= AER_WIDTH'(n_q);
            ev_tstep_q <= 1'b0;
         end

         if (advance) begin
            if (!last_n) begin
               n_q <= n_q + 1'b1;
            end else begin
               addr_q     <= TSTEP_ADDR;
               ev_tstep_q <= 1'b1;
            end
         end

         // End-of-step marker retired: rewind to pixel 0 of the next step.
         // On the final step t is left alone; WAIT_DONE does not use it.
         if ((state == S_ACKL) && !AERIN_ACK && ev_tstep_q) begin
            n_q <= '0;
            if (!last_t) t_q <= t_q + 1'b1;
         end

         if ((state == S_WAIT_DONE) && CORE_DONE) good_q <= CORE_GOODNESS;
      end
   end

endmodule

// File: tb/tb_aer_sample_sequencer.sv
// -----------------------------------------------------------------------------
// Testbench for aer_sample_sequencer. A reference model expands the pixel
// array into the expected event list (per step: every pixel above the step
// threshold, then the step marker). A compare process checks the AER stream,
// handshake rules, latched mode, goodness and DONE every cycle.
// -----------------------------------------------------------------------------
module tb_aer_sample_sequencer;
   localparam int TIME_STEP    = 8;
   localparam int INPUT_NEURON = 784;
   localparam int PIX_WIDTH    = 8;
   localparam int STEP_SIZE    = (2 ** PIX_WIDTH) / TIME_STEP;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        START = 1'b0;
   logic        SAMPLE_IS_POS = 1'b0;
   logic        SAMPLE_IS_TRAIN = 1'b0;
   logic        BUSY, DONE, PIX_REN;
   logic [9:0]  PIX_RADDR;
   logic [7:0]  PIX_RDATA = '0;
   logic [11:0] AERIN_ADDR;
   logic        AERIN_REQ;
   logic        AERIN_ACK = 1'b0;
   logic        IS_POS, IS_TRAIN;
   logic        CORE_DONE = 1'b0;
   logic [31:0] CORE_GOODNESS = '0;
   logic [31:0] GOODNESS;

   aer_sample_sequencer #(
      .TIME_STEP(TIME_STEP), .INPUT_NEURON(INPUT_NEURON), .PIX_WIDTH(PIX_WIDTH),
      .NEUR_ADDR_WIDTH(10), .AER_WIDTH(12), .TSTEP_ADDR(12'hFFF)
   ) dut (
      .CLK(CLK), .RST(RST), .START(START),
      .SAMPLE_IS_POS(SAMPLE_IS_POS), .SAMPLE_IS_TRAIN(SAMPLE_IS_TRAIN),
      .BUSY(BUSY), .DONE(DONE), .PIX_REN(PIX_REN), .PIX_RADDR(PIX_RADDR),
      .PIX_RDATA(PIX_RDATA), .AERIN_ADDR(AERIN_ADDR), .AERIN_REQ(AERIN_REQ),
      .AERIN_ACK(AERIN_ACK), .IS_POS(IS_POS), .IS_TRAIN(IS_TRAIN),
      .CORE_DONE(CORE_DONE), .CORE_GOODNESS(CORE_GOODNESS), .GOODNESS(GOODNESS)
   );

   always #5 CLK = ~CLK;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   // Model / scoreboard state
   logic [7:0]  pix [INPUT_NEURON];
   int          exp_q [$];
   int          tot_ev = 0;
   int          ev_cnt = 0, tstep_cnt = 0, rd_cnt = 0, done_cnt = 0;
   int          first_cyc_exp = -1, start_cyc = 0;
   bit          first_seen = 0, done_allowed = 0;
   logic [31:0] exp_good = '0;
   logic        exp_pos = 1'b0, exp_train = 1'b0;
   int          ack_fixed = -1;
   int          exp_addr;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, expv, $time);
      end
   endtask

   // Expected event list from the rate-coding rule.
   function automatic void build_model();
      exp_q.delete();
      for (int t = 0; t < TIME_STEP; t++) begin
         for (int n = 0; n < INPUT_NEURON; n++)
            if (int'(pix[n]) > t * STEP_SIZE) exp_q.push_back(n);
         exp_q.push_back('hFFF);
      end
      tot_ev = exp_q.size();
   endfunction

   // Synchronous sample RAM: data follows a read by one cycle.
   always @(negedge CLK) if (PIX_REN) PIX_RDATA = pix[PIX_RADDR];

   // 4-phase ACK responder with a per-transition delay.
   int acnt = 0;
   function automatic int pick_delay();
      return (ack_fixed >= 0) ? ack_fixed : int'($urandom_range(0, 3));
   endfunction
   always @(negedge CLK) begin
      if (AERIN_ACK != AERIN_REQ) begin
         if (acnt == 0) AERIN_ACK = AERIN_REQ;
         else           acnt--;
      end else begin
         acnt = pick_delay();
      end
   end

   // Per-cycle compare process.
   logic        prev_req = 1'b0, prev_done = 1'b0;
   logic [11:0] prev_addr = '0;
   always @(posedge CLK) begin
      #1;
      if (RST) begin
         prev_req  = 1'b0;
         prev_done = 1'b0;
      end else begin
         if (PIX_REN) rd_cnt++;
         if (AERIN_REQ && !prev_req) begin
            if (exp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_event: got %0h expected none", AERIN_ADDR);
            end else begin
               exp_addr = exp_q.pop_front();
               chk("event_addr", AERIN_ADDR, exp_addr);
               if (exp_addr == 'hFFF) tstep_cnt++;
            end
            ev_cnt++;
            if (!first_seen) begin
               first_seen = 1;
               if (first_cyc_exp >= 0) chk("first_req_cycle", cyc - start_cyc, first_cyc_exp);
            end
         end
         if (AERIN_REQ && prev_req) chk("addr_stable", AERIN_ADDR, prev_addr);
         // ACK sampled high while requesting: REQ must be low the next cycle.
         if (prev_req && AERIN_ACK) chk("req_drop_after_ack", AERIN_REQ, 0);
         chk("goodness", GOODNESS, exp_good);
         chk("is_pos", IS_POS, exp_pos);
         chk("is_train", IS_TRAIN, exp_train);
         if (prev_done) begin
            chk("done_width", DONE, 0);
            chk("busy_after_done", BUSY, 0);
         end
         if (DONE) begin
            chk("done_allowed", done_allowed, 1);
            chk("events_left_at_done", exp_q.size(), 0);
            done_allowed = 0;
            done_cnt++;
         end
         prev_req  = AERIN_REQ;
         prev_addr = AERIN_ADDR;
         prev_done = DONE;
      end
   end

   task automatic start_sample(input logic pos, input logic train, input int first_exp);
      build_model();
      ev_cnt = 0; tstep_cnt = 0; rd_cnt = 0; done_cnt = 0;
      first_seen = 0; first_cyc_exp = first_exp;
      @(negedge CLK);
      SAMPLE_IS_POS = pos; SAMPLE_IS_TRAIN = train; START = 1'b1;
      start_cyc = cyc; exp_pos = pos; exp_train = train;
      @(negedge CLK);
      START = 1'b0; SAMPLE_IS_POS = ~pos; SAMPLE_IS_TRAIN = ~train;
      chk("busy_cycle1", BUSY, 1);
      chk("ren_cycle1", PIX_REN, 1);
      chk("raddr_cycle1", PIX_RADDR, 0);
   endtask

   task automatic finish_sample(input logic [31:0] good, input bit disturb);
      int budget;
      if (disturb) begin
         @(negedge CLK); START = 1'b1;       // START while busy
         @(negedge CLK); START = 1'b0;
         budget = 30000;
         while (tstep_cnt < 3 && budget > 0) begin @(negedge CLK); budget--; end
         chk("reach_step3", budget > 0, 1);
         START = 1'b1; CORE_DONE = 1'b1; CORE_GOODNESS = 32'hDEADBEEF;
         @(negedge CLK);
         START = 1'b0; CORE_DONE = 1'b0;
      end
      budget = 60000;
      while (!(ev_cnt == tot_ev && !AERIN_REQ && !AERIN_ACK) && budget > 0) begin
         @(negedge CLK); budget--;
      end
      chk("stream_complete", budget > 0, 1);
      repeat (3) @(negedge CLK);
      chk("busy_in_wait_done", BUSY, 1);
      chk("no_early_done", done_cnt, 0);
      CORE_GOODNESS = good; CORE_DONE = 1'b1;
      exp_good = good; done_allowed = 1;
      @(negedge CLK);
      CORE_DONE = 1'b0; CORE_GOODNESS = $urandom;
      repeat (4) @(negedge CLK);
      chk("done_count", done_cnt, 1);
      chk("busy_idle", BUSY, 0);
      chk("read_count", rd_cnt, INPUT_NEURON * TIME_STEP);
   endtask

   initial begin
      #1_500_000;
      $display("FAIL watchdog: got timeout expected completion");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      int budget;
      foreach (pix[i]) pix[i] = '0;
      repeat (3) @(negedge CLK);
      // Reset values
      chk("rst_busy", BUSY, 0);       chk("rst_done", DONE, 0);
      chk("rst_ren", PIX_REN, 0);     chk("rst_req", AERIN_REQ, 0);
      chk("rst_addr", AERIN_ADDR, 0); chk("rst_good", GOODNESS, 0);
      chk("rst_pos", IS_POS, 0);      chk("rst_train", IS_TRAIN, 0);
      RST = 1'b0;
      repeat (2) @(negedge CLK);

      // All-zero sample, 6-cycle ACK: markers only; first marker after
      // 784 two-cycle pixels.
      ack_fixed = 6;
      build_model();
      chk("model_zero_len", tot_ev, 8);
      start_sample(1'b1, 1'b0, 2 * INPUT_NEURON + 1);
      finish_sample(32'h12345678, 0);
      // Mode stays latched while idle with toggling inputs.
      repeat (5) begin @(negedge CLK); SAMPLE_IS_POS = ~SAMPLE_IS_POS; SAMPLE_IS_TRAIN = $urandom; end

      // Pixel 5 at full scale: spikes every step.
      ack_fixed = -1;
      pix[5] = 8'd255;
      build_model();
      chk("model_p5_len", tot_ev, 16);
      chk("model_p5_e0", exp_q[0], 5);
      chk("model_p5_e1", exp_q[1], 'hFFF);
      start_sample(1'b0, 1'b1, -1);
      finish_sample($urandom, 0);
      pix[5] = '0;

      // Threshold boundary: 33 spikes in steps 0 and 1, 32 only in step 0.
      pix[783] = 8'd32; pix[0] = 8'd33;
      build_model();
      chk("model_bnd_len", tot_ev, 11);
      chk("model_bnd_e1", exp_q[1], 12'h30F);
      chk("model_bnd_e3", exp_q[3], 0);
      start_sample(1'b1, 1'b1, 3);
      finish_sample(32'hCAFE0001, 0);

      // Sparse random sample with START/CORE_DONE disturbances while busy.
      foreach (pix[i]) pix[i] = ($urandom_range(0, 63) == 0) ? 8'($urandom_range(1, 255)) : 8'd0;
      pix[10] = 8'd200;
      start_sample($urandom, $urandom, -1);
      finish_sample($urandom, 1);

      // Reset while a step-2 request is pending, then replay from scratch.
      start_sample(1'b1, 1'b0, -1);
      budget = 30000;
      while (!(tstep_cnt == 2 && AERIN_REQ) && budget > 0) begin @(negedge CLK); budget--; end
      chk("reach_step2_req", budget > 0, 1);
      RST = 1'b1;
      exp_good = '0; exp_pos = 1'b0; exp_train = 1'b0; done_allowed = 0;
      #1;
      chk("arst_req", AERIN_REQ, 0);  chk("arst_busy", BUSY, 0);
      chk("arst_addr", AERIN_ADDR, 0); chk("arst_good", GOODNESS, 0);
      chk("arst_pos", IS_POS, 0);     chk("arst_ren", PIX_REN, 0);
      repeat (2) @(negedge CLK);
      RST = 1'b0;
      exp_q.delete();
      budget = 100;
      while (AERIN_ACK && budget > 0) begin @(negedge CLK); budget--; end
      chk("ack_released", AERIN_ACK, 0);
      repeat (2) @(negedge CLK);
      chk("idle_after_rst", BUSY, 0);
      start_sample(1'b0, 1'b0, -1);
      finish_sample(32'h0BADF00D, 0);

      repeat (3) @(negedge CLK);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/aer_sample_sequencer.md
# aer_sample_sequencer

Sequencer that drives one input sample into the SNN core's AER input port. It reads per-pixel intensities from an external sample RAM and rate-codes them into spike events over TIME_STEP time steps, emitting an end-of-step marker after each step. It then waits for the core's sample-finished pulse and latches GOODNESS. It sits between the host/sample buffer and the core's AERIN_REQ/AERIN_ACK, IS_POS and IS_TRAIN inputs.

## Interface
- TIME_STEP, 8, time steps per sample; power of 2, ≤ 2^PIX_WIDTH
- INPUT_NEURON, 784, pixels/input neurons per sample
- PIX_WIDTH, 8, pixel intensity width
- NEUR_ADDR_WIDTH, 10, pixel/neuron index width
- AER_WIDTH, 12, AER address width
- TSTEP_ADDR, 12'hFFF, AER address of the end-of-time-step marker
- CLK  in  1  clock
- RST  in  1  reset, asynchronous, active-high
- START  in  1  one-cycle start pulse; honoured only in IDLE
- SAMPLE_IS_POS  in  1  polarity for this sample, latched at START
- SAMPLE_IS_TRAIN  in  1  train/infer for this sample, latched at START
- BUSY  out  1  high from the cycle after an accepted START until DONE
- DONE  out  1  one-cycle pulse when GOODNESS is valid
- PIX_REN  out  1  sample RAM read enable
- PIX_RADDR  out  NEUR_ADDR_WIDTH  sample RAM address
- PIX_RDATA  in  PIX_WIDTH  read data, valid one cycle after PIX_REN
- AERIN_ADDR  out  AER_WIDTH  event address to core
- AERIN_REQ  out  1  event request, 4-phase
- AERIN_ACK  in  1  event acknowledge from core
- IS_POS, IS_TRAIN  out  1 each  latched sample mode to core
- CORE_DONE  in  1  core sample-finished pulse
- CORE_GOODNESS  in  32  core goodness value
- GOODNESS  out  32  goodness latched on CORE_DONE

## Operation
- States: IDLE, READ, EVAL, REQ, ACKL, TSTEP, WAIT_DONE, FIN.
- IDLE: START → latch IS_POS/IS_TRAIN, clear neuron index n and step t → READ.
- READ: PIX_REN=1, PIX_RADDR=n → EVAL.
- EVAL: spike iff PIX_RDATA > (t << SHIFT), SHIFT = PIX_WIDTH − log2(TIME_STEP), with an unsigned compare at PIX_WIDTH bits. On spike, set AERIN_ADDR = zero-extended n and go to REQ. Otherwise advance.
- Advance: if n < INPUT_NEURON−1, n+1 → READ. Else set AERIN_ADDR = TSTEP_ADDR → TSTEP.
- REQ/TSTEP: hold AERIN_REQ=1 with AERIN_ADDR stable until AERIN_ACK=1 is sampled, then REQ=0 → ACKL.
- ACKL: wait for AERIN_ACK=0.
  - After a spike event: advance.
  - After a TSTEP event: clear n. If t < TIME_STEP−1, t+1 → READ; else → WAIT_DONE.
- WAIT_DONE: CORE_DONE=1 → GOODNESS ← CORE_GOODNESS → FIN.
- FIN: DONE=1 for one cycle → IDLE.
- Pixel 0 never spikes. Pixel 2^PIX_WIDTH−1 spikes every step. Spike count per pixel = number of t with pixel > t·2^SHIFT.
- START outside IDLE is ignored. CORE_DONE outside WAIT_DONE is ignored. AERIN_ACK outside REQ/TSTEP/ACKL is ignored.
- IS_POS/IS_TRAIN hold their latched values until the next accepted START, including while idle.

## Timing
- Reset values: all outputs 0, including GOODNESS=0 and AERIN_ADDR=0; state IDLE.
- RST mid-handshake drops AERIN_REQ asynchronously. The core's resulting ACK is ignored after reset.
- START at cycle 0 → BUSY=1 and first PIX_REN at cycle 1 → EVAL at cycle 2 → REQ=1 earliest at cycle 3.
- A non-spiking pixel costs 2 cycles (READ+EVAL).
- A spiking pixel costs 2 cycles plus handshake: REQ deasserts the cycle after ACK=1 is sampled. The next READ follows the cycle after ACK=0 is sampled.
- AERIN_ADDR changes only while REQ=0.
- CORE_DONE sampled at cycle k in WAIT_DONE → GOODNESS updated at k+1, DONE=1 at k+1, BUSY=0 and IDLE at k+2.
- GOODNESS holds its value until the next CORE_DONE accepted in WAIT_DONE.
- No timeout: the sequencer waits indefinitely for ACK and CORE_DONE.

## Test plan
- All-zero sample, ACK responder with 6-cycle delay → exactly 8 events, all 0xFFF. Then WAIT_DONE. CORE_DONE with GOODNESS 0x12345678 → GOODNESS=0x12345678, one DONE pulse.
- Pixel[5]=255, others 0 → event stream is 0x005, 0xFFF repeated 8 times.
- Pixel[783]=32 and pixel[0]=33 → step 0: 0x000, 0x30F, 0xFFF. Step 1: 0x000, 0xFFF. Steps 2–7: 0xFFF only.
- START pulses during BUSY and a CORE_DONE during step 3 → no restart, no early DONE, full stream completes normally.
- RST asserted while REQ=1 mid-step 2 → REQ=0 immediately, all outputs at reset values. A new START replays from step 0 with neuron 0.
- SAMPLE_IS_POS=1, SAMPLE_IS_TRAIN=0 at START, toggled afterwards → IS_POS=1 and IS_TRAIN=0 held through DONE and while idle.
